// File: rtl/noc_pkg.sv
// Shared types and constants for the NoC output-port scheduler.
// Flit layout: [FLIT_W-1] head, [FLIT_W-2] tail, remaining bits payload.
package noc_pkg;

   localparam int unsigned DEF_NUM_IN = 4;
   localparam int unsigned DEF_FLIT_W = 16;
   localparam int unsigned HEAD_BIT   = DEF_FLIT_W - 1;
   localparam int unsigned TAIL_BIT   = DEF_FLIT_W - 2;

   typedef logic [DEF_FLIT_W-1:0] flit_t;

   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } arb_state_e;

   // Modulo-n increment; handles non-power-of-two port counts
   function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
      return (v + 1 >= n) ? 0 : v + 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr,
// wrapping at N-1 -> 0.
module rr_arbiter #(
   parameter int unsigned N  = 4,
   parameter int unsigned IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  gnt_c,
   output logic [IW-1:0] idx_c,
   output logic          any_c
);

   logic [IW-1:0] cand;

   always_comb begin
      gnt_c = '0;
      idx_c = '0;
      any_c = 1'b0;
      cand  = '0;
      for (int unsigned k = 0; k < N; k++) begin
         cand = IW'((32'(ptr) + k) % N);
         if (!any_c && req[cand]) begin
            any_c       = 1'b1;
            idx_c       = cand;
            gnt_c[cand] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/noc_port_arbiter.sv
// Wormhole output-port scheduler: round-robin over input FIFOs, grant locked
// head->tail, absorbs the FIFO read latency and feeds a 2-entry skid buffer.
module noc_port_arbiter
   import noc_pkg::*;
#(
   parameter int unsigned NUM_IN = DEF_NUM_IN,
   parameter int unsigned FLIT_W = DEF_FLIT_W,
   parameter int unsigned GNT_W  = $clog2(NUM_IN)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_IN-1:0]        in_empty,
   output logic [NUM_IN-1:0]        in_rd_en,
   input  logic [NUM_IN*FLIT_W-1:0] in_flit,
   output logic                     out_valid,
   output logic [FLIT_W-1:0]        out_flit,
   input  logic                     out_ready,
   output logic [GNT_W-1:0]         grant_id,
   output logic                     busy
);

   localparam int unsigned TAIL_POS = FLIT_W - 2;

   arb_state_e        state_q, state_d;
   logic [GNT_W-1:0]  grant_q, grant_d;
   logic [GNT_W-1:0]  ptr_q, ptr_d, arb_ptr, arb_idx;
   logic [NUM_IN-1:0] arb_gnt;
   logic              arb_any;
   logic              inflight_q, pop, tail_det, slot_free, deq;
   logic [1:0]        occ_q;
   logic [FLIT_W-1:0] buf_q [2];
   logic [FLIT_W-1:0] in_flit_a [NUM_IN];
   logic [FLIT_W-1:0] cap_flit;

   always_comb begin
      for (int unsigned i = 0; i < NUM_IN; i++) begin
         in_flit_a[i] = in_flit[i*FLIT_W +: FLIT_W];
      end
   end

   // The flit read last cycle always comes from the FIFO still held in grant_q
   assign cap_flit  = in_flit_a[grant_q];
   assign tail_det  = inflight_q & cap_flit[TAIL_POS];
   assign out_valid = (occ_q != 2'd0);
   assign out_flit  = buf_q[0];
   assign deq       = out_valid & out_ready;
   assign slot_free = (3'(occ_q) + 3'(inflight_q) - 3'(deq)) < 3'd2;
   assign grant_id  = grant_q;
   assign busy      = (state_q == LOCKED);

   // On a tail the pointer moves past the finishing input before re-arbitrating
   assign arb_ptr = tail_det ? GNT_W'(wrap_inc(32'(grant_q), NUM_IN)) : ptr_q;

   rr_arbiter #(
      .N  (NUM_IN),
      .IW (GNT_W)
   ) u_rr (
      .req   (~in_empty),
      .ptr   (arb_ptr),
      .gnt_c (arb_gnt),
      .idx_c (arb_idx),
      .any_c (arb_any)
   );

   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      ptr_d    = ptr_q;
      pop      = 1'b0;
      in_rd_en = '0;
      if (!rst) begin
         if (state_q == IDLE || tail_det) begin
            state_d = IDLE;
            ptr_d   = arb_ptr;
            if (arb_any && slot_free) begin
               pop      = 1'b1;
               in_rd_en = arb_gnt;
               grant_d  = arb_idx;
               state_d  = LOCKED;
            end
         end else if (!in_empty[grant_q] && slot_free) begin
            pop      = 1'b1;
            in_rd_en = NUM_IN'(1) << grant_q;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         grant_q    <= '0;
         ptr_q      <= '0;
         inflight_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         ptr_q      <= ptr_d;
         inflight_q <= pop;
      end
   end

   // Skid buffer: entry 0 is the presented flit; push is the flit read last cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         occ_q    <= 2'd0;
         buf_q[0] <= '0;
         buf_q[1] <= '0;
      end else begin
         case ({deq, inflight_q})
            2'b01: begin
               if (occ_q == 2'd0) buf_q[0] <= cap_flit;
               else               buf_q[1] <= cap_flit;
               occ_q <= occ_q + 2'd1;
            end
            2'b10: begin
               buf_q[0] <= buf_q[1];
               occ_q    <= occ_q - 2'd1;
            end
            2'b11: begin
               if (occ_q == 2'd1) begin
                  buf_q[0] <= cap_flit;
               end else begin
                  buf_q[0] <= buf_q[1];
                  buf_q[1] <= cap_flit;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_noc_port_arbiter.sv
// Bench for noc_port_arbiter: queue-based FIFO models, packet-level scoreboard,
// directed latency/ordering scenarios and randomized wormhole traffic.
module tb_noc_port_arbiter;
   import noc_pkg::*;

   localparam int unsigned N  = 4;
   localparam int unsigned FW = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [N-1:0]  in_empty;
   logic [N-1:0]  in_rd_en;
   logic [N*FW-1:0] in_flit;
   logic          out_valid;
   logic [FW-1:0] out_flit;
   logic          out_ready;
   logic [1:0]    grant_id;
   logic          busy;

   flit_t fifo_dout [N];
   flit_t fq [N][$];
   flit_t sb [N][$];
   logic [N-1:0] rd_snap;

   typedef struct {
      flit_t flit;
      int    cyc;
      logic  busy;
   } log_t;
   log_t olog[$];

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int cur_src = -1;
   int seq [N];
   int pushed = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < N; g++) begin : g_flit
      assign in_flit[g*FW +: FW] = fifo_dout[g];
   end

   noc_port_arbiter #(.NUM_IN(N), .FLIT_W(FW), .GNT_W(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_empty  (in_empty),
      .in_rd_en  (in_rd_en),
      .in_flit   (in_flit),
      .out_valid (out_valid),
      .out_flit  (out_flit),
      .out_ready (out_ready),
      .grant_id  (grant_id),
      .busy      (busy)
   );

   always @(posedge clk) cyc++;

   // Input FIFO models: registered read data, empty flag updated at the edge
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < N; i++) begin
            fq[i].delete();
            sb[i].delete();
            fifo_dout[i] <= '0;
         end
         in_empty <= '1;
      end else begin
         for (int i = 0; i < N; i++) begin
            if (rd_snap[i] && fq[i].size() != 0) fifo_dout[i] <= fq[i].pop_front();
            in_empty[i] <= (fq[i].size() == 0);
         end
      end
   end

   // Monitor: read-enable legality and per-packet output ordering
   always @(negedge clk) begin
      int    src;
      flit_t exp_f;
      rd_snap = in_rd_en;
      if (rst) begin
         cur_src = -1;
      end else begin
         checks++;
         assert ($onehot0(in_rd_en) && ((in_rd_en & in_empty) == '0)) else begin
            errors++;
            $error("FAIL rd_en_legal: rd_en=%b empty=%b required one-hot0 and no read of an empty FIFO",
                   in_rd_en, in_empty);
         end
         if (out_valid && out_ready) begin
            src   = int'(out_flit[13:12]);
            exp_f = (sb[src].size() != 0) ? sb[src][0] : '0;
            checks++;
            assert (sb[src].size() != 0 && out_flit === exp_f) else begin
               errors++;
               $error("FAIL out_order: observed=%h expected=%h (src %0d)", out_flit, exp_f, src);
            end
            if (sb[src].size() != 0) void'(sb[src].pop_front());
            if (cur_src >= 0) begin
               checks++;
               assert (src === cur_src) else begin
                  errors++;
                  $error("FAIL no_interleave: observed src=%0d expected src=%0d", src, cur_src);
               end
            end
            cur_src = out_flit[TAIL_BIT] ? -1 : src;
            olog.push_back('{out_flit, cyc, busy});
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic flit_t mk(input int src, input logic h, input logic t);
      flit_t f;
      f           = '0;
      f[HEAD_BIT] = h;
      f[TAIL_BIT] = t;
      f[13:12]    = 2'(src);
      f[11:0]     = 12'(seq[src]);
      seq[src]++;
      return f;
   endfunction

   task automatic push(input int src, input logic h, input logic t, output flit_t f);
      f = mk(src, h, t);
      fq[src].push_back(f);
      sb[src].push_back(f);
      pushed++;
   endtask

   task automatic wait_log(input int n, input string tag);
      int k;
      k = 0;
      while (olog.size() < n && k < 200) begin
         step();
         k++;
      end
      chk({tag, "_flit_count"}, 64'(olog.size() >= n), 64'(1));
   endtask

   function automatic int log_src(input int j);
      if (j < olog.size()) return int'(olog[j].flit[13:12]);
      return -1;
   endfunction

   function automatic int log_cyc(input int j);
      if (j < olog.size()) return olog[j].cyc;
      return -1;
   endfunction

   task automatic chk_reset(input string tag);
      chk({tag, "_out_valid"}, 64'(out_valid), 64'(0));
      chk({tag, "_out_flit"},  64'(out_flit),  64'(0));
      chk({tag, "_busy"},      64'(busy),      64'(0));
      chk({tag, "_grant_id"},  64'(grant_id),  64'(0));
      chk({tag, "_rd_en"},     64'(in_rd_en),  64'(0));
   endtask

   initial begin
      flit_t f, h4;
      int    k0;
      int    gq [N][$];
      int    n;

      for (int i = 0; i < N; i++) seq[i] = 0;
      out_ready = 1'b0;
      #2 rst = 1'b1;
      @(negedge clk);
      chk_reset("reset");
      step();
      rst = 1'b0;
      out_ready = 1'b1;
      step(2);

      // Four single-flit packets: served 0,1,2,3 back to back
      olog.delete();
      k0 = cyc;
      for (int i = 0; i < N; i++) push(i, 1'b1, 1'b1, f);
      wait_log(4, "rr4");
      for (int j = 0; j < 4; j++) begin
         chk($sformatf("rr4_src%0d", j), 64'(log_src(j)), 64'(j));
         chk($sformatf("rr4_cyc%0d", j), 64'(log_cyc(j)), 64'(k0 + 3 + j));
      end
      step(3);

      // Pointer wrapped to 0: input 0 wins over input 3
      olog.delete();
      push(3, 1'b1, 1'b1, f);
      push(0, 1'b1, 1'b1, f);
      wait_log(2, "wrap");
      chk("wrap_first", 64'(log_src(0)), 64'(0));
      chk("wrap_second", 64'(log_src(1)), 64'(3));
      step(3);

      // Three-flit packet: output two cycles after first read, busy gone at tail
      olog.delete();
      k0 = cyc;
      push(0, 1'b1, 1'b0, f);
      push(0, 1'b0, 1'b0, f);
      push(0, 1'b0, 1'b1, f);
      wait_log(3, "pkt3");
      for (int j = 0; j < 3; j++)
         chk($sformatf("pkt3_cyc%0d", j), 64'(log_cyc(j)), 64'(k0 + 3 + j));
      chk("pkt3_busy_head", 64'((olog.size() > 0) ? olog[0].busy : 1'b0), 64'(1));
      chk("pkt3_busy_tail", 64'((olog.size() > 2) ? olog[2].busy : 1'b1), 64'(0));
      step(3);

      // Granted input starves mid-packet: other input must wait for the tail
      olog.delete();
      push(1, 1'b1, 1'b0, f);
      push(2, 1'b1, 1'b1, f);
      step(8);
      chk("stall_count", 64'(olog.size()), 64'(1));
      chk("stall_src", 64'(log_src(0)), 64'(1));
      chk("stall_busy", 64'(busy), 64'(1));
      chk("stall_grant", 64'(grant_id), 64'(1));
      push(1, 1'b0, 1'b0, f);
      push(1, 1'b0, 1'b1, f);
      wait_log(4, "stall");
      chk("stall_o1", 64'(log_src(1)), 64'(1));
      chk("stall_o2", 64'(log_src(2)), 64'(1));
      chk("stall_o3", 64'(log_src(3)), 64'(2));
      step(3);

      // Backpressure: two flits absorbed, reads stop, output held steady
      olog.delete();
      out_ready = 1'b0;
      push(2, 1'b1, 1'b0, h4);
      push(2, 1'b0, 1'b0, f);
      push(2, 1'b0, 1'b0, f);
      push(2, 1'b0, 1'b1, f);
      step(3);
      for (int j = 0; j < 5; j++) begin
         @(negedge clk);
         chk($sformatf("bp_valid%0d", j), 64'(out_valid), 64'(1));
         chk($sformatf("bp_flit%0d", j), 64'(out_flit), 64'(h4));
         chk($sformatf("bp_rd%0d", j), 64'(in_rd_en), 64'(0));
      end
      chk("bp_fifo_left", 64'(fq[2].size()), 64'(2));
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      wait_log(4, "bp");
      chk("bp_first", 64'((olog.size() > 0) ? olog[0].flit : '0), 64'(h4));
      step(3);
      chk("bp_no_dup", 64'(olog.size()), 64'(4));

      // Reset mid-packet, then arbitration restarts from input 0
      olog.delete();
      push(2, 1'b1, 1'b0, f);
      push(2, 1'b0, 1'b0, f);
      push(2, 1'b0, 1'b1, f);
      n = 0;
      while (olog.size() < 2 && n < 50) begin
         step();
         n++;
      end
      chk("rst_mid_seen_body", 64'(olog.size()), 64'(2));
      rst = 1'b1;
      @(negedge clk);
      chk_reset("rst_mid");
      step();
      rst = 1'b0;
      step(2);
      olog.delete();
      push(3, 1'b1, 1'b1, f);
      push(1, 1'b1, 1'b1, f);
      wait_log(2, "post_rst");
      chk("post_rst_first", 64'(log_src(0)), 64'(1));
      chk("post_rst_second", 64'(log_src(1)), 64'(3));
      step(3);

      // Random wormhole traffic with random backpressure
      olog.delete();
      pushed = 0;
      for (int c = 0; c < 10000; c++) begin
         out_ready = ($urandom_range(0, 3) != 0);
         for (int i = 0; i < N; i++) begin
            if (gq[i].size() == 0 && $urandom_range(0, 7) == 0) begin
               n = $urandom_range(1, 4);
               for (int j = 0; j < n; j++) gq[i].push_back({int'(j == 0), int'(j == n - 1)} == 0 ? 0 : (j == 0 ? 2 : 0) + (j == n - 1 ? 1 : 0));
            end
            if (gq[i].size() != 0 && $urandom_range(0, 2) != 0) begin
               n = gq[i].pop_front();
               push(i, n[1], n[0], f);
            end
         end
         step();
      end
      out_ready = 1'b1;
      for (int i = 0; i < N; i++) begin
         while (gq[i].size() != 0) begin
            n = gq[i].pop_front();
            push(i, n[1], n[0], f);
         end
      end
      n = 0;
      while ((fq[0].size() + fq[1].size() + fq[2].size() + fq[3].size() != 0 ||
              sb[0].size() + sb[1].size() + sb[2].size() + sb[3].size() != 0 || out_valid) && n < 3000) begin
         step();
         n++;
      end
      chk("rand_drained", 64'(sb[0].size() + sb[1].size() + sb[2].size() + sb[3].size()), 64'(0));
      chk("rand_flit_total", 64'(olog.size()), 64'(pushed));
      chk("rand_idle_busy", 64'(busy), 64'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
